vend_seq: RTL and testbench
===========================

Name: vend_seq

Overview:
- Sequencing controller in front of the vending-machine `dfa` block.
- Collects coin pulses from the acceptor, which may arrive at any time and simultaneously, and queues them per denomination.
- Presents the coins to `dfa` one at a time as single-cycle one-hot pulses, then samples the `dfa` outputs.
- Drives the soda dispenser and the change hopper through req/ack handshakes, so the `dfa` never sees overlapping coins.

Parameters:
- CNT_W, 2: width of each per-denomination pending-coin counter; max pending per type is 2^CNT_W-1.
- DFA_LAT, 1: cycles from the issue pulse to the cycle in which `dfa` outputs are sampled (range 1..7).
- TO_CYC, 64: maximum cycles a req may wait for its ack before a fault is declared.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coin1  in  1  1-unit coin accepted; single-cycle pulse.
- coin2  in  1  2-unit coin accepted; single-cycle pulse.
- coin5  in  1  5-unit coin accepted; single-cycle pulse.
- dfa_in1  out  1  one-cycle pulse to `dfa` in1.
- dfa_in2  out  1  one-cycle pulse to `dfa` in2.
- dfa_in5  out  1  one-cycle pulse to `dfa` in5.
- dfa_out1  in  1  `dfa` change: one 1-unit coin.
- dfa_out2  in  1  `dfa` change: one 2-unit coin.
- dfa_out2x2  in  1  `dfa` change: two 2-unit coins.
- dfa_soda  in  1  `dfa` vend indication.
- soda_req  out  1  soda dispense request.
- soda_ack  in  1  soda dispenser acknowledge.
- hop_req  out  1  change hopper request, one coin per handshake.
- hop_sel  out  1  coin selected for hopper: 0 = 1-unit, 1 = 2-unit.
- hop_ack  in  1  hopper acknowledge.
- coin_rej  out  1  one-cycle pulse: coin arrived while its counter was full; acceptor returns it.
- busy  out  1  high in any state other than IDLE.
- fault  out  1  sticky handshake-timeout flag.

Behaviour:
- Clocking and reset:
  - Single clock; reset is asynchronous, active-low on rst_n, applied immediately on assertion.
  - Reset clears all counters and returns the FSM to IDLE.
  - Reset values: every output is 0.
  - Reset mid-transaction discards any pending coins and any undispensed change.
- Pending counters p1, p2, p5 (CNT_W bits each):
  - Each counter increments on its coin pulse.
  - A coin pulse on a full counter does not increment it; coin_rej pulses in the next cycle instead. Multiple rejections in one cycle produce one pulse.
  - Simultaneous pulses on different types are all counted in the same cycle.
  - An increment and the arbiter's decrement in the same cycle leave the counter unchanged.
- Arbiter: fixed priority 5 > 2 > 1, evaluated in IDLE only.
- FSM states: IDLE, ISSUE, WAIT, SODA, CHANGE, FAULT.
  - IDLE -> ISSUE when any counter is nonzero; the winning counter is decremented on this transition.
  - ISSUE: exactly one dfa_inN is high for this one cycle. -> WAIT.
  - WAIT: counts DFA_LAT cycles after ISSUE. In the last cycle it samples the `dfa` outputs:
    - n2 = dfa_out2 + 2*dfa_out2x2 (3-bit).
    - n1 = dfa_out1.
    - vend = dfa_soda.
    - Next state is SODA if vend, else CHANGE if n1+n2 > 0, else IDLE.
  - SODA: soda_req held high until soda_ack is sampled high, then dropped the next cycle. -> CHANGE if change is owed, else IDLE.
  - CHANGE:
    - One handshake per coin, all 2-unit coins first, then 1-unit.
    - hop_sel is stable for the whole time hop_req is high.
    - Each ack decrements the matching count; hop_req is low for at least one cycle between handshakes.
    - -> IDLE when n1 = n2 = 0.
- Acks: an ack that arrives while its req is low is ignored. An ack in the same cycle req rises counts; the minimum handshake is 2 cycles.
- Timeout and fault:
  - A timeout counter runs while any req is high and resets on each ack.
  - If TO_CYC is reached: fault is set, the req drops, the FSM enters FAULT.
  - FAULT is held until reset. In FAULT no issue occurs; counters still accept coins and rejections still pulse.
- busy = (state != IDLE).

Decomposition:
- Package vend_pkg holds:
  - FSM state enum.
  - Coin codes: C1, C2, C5.
  - Default constants for DFA_LAT and TO_CYC.
- One sub-module, vend_coin_cnt: a saturating up/down counter with a full flag. It is instantiated three times.

Test Plan:
- Single coin: coin5 pulse at t0 → dfa_in5 high exactly one cycle at t0+2 (one cycle to register, one to ISSUE); busy rises at t0+2 and returns to 0 after WAIT when `dfa` reports nothing.
- Simultaneous coins: coin1, coin2 and coin5 pulsed in the same cycle → issue order dfa_in5, dfa_in2, dfa_in1; no coin_rej.
- Overflow: with no issuing (SODA held waiting on ack), pulse coin1 four times → p1 = 3, and coin_rej pulses once on the fourth coin.
- Vend plus change: bench `dfa` model returns soda=1, out2x2=1, out1=1 → soda_req handshake first, then hop_req with hop_sel=1 twice, then hop_sel=0 once; ack delays of 0 and 5 cycles both work.
- Timeout: hold hop_ack low → fault=1 after 64 cycles, hop_req=0, no further dfa_in pulses; an rst_n low pulse clears everything to 0.
- Async reset mid-WAIT with p2 = 2 → outputs are 0 immediately, without waiting for a clock edge; after reset release no dfa_in pulse occurs.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending-machine sequencing controller.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SODA,
    CHANGE,
    FAULT
  } state_t;

  typedef enum logic [1:0] {
    C_NONE,
    C1,
    C2,
    C5
  } coin_t;

  localparam int DFA_LAT_DEF = 1;
  localparam int TO_CYC_DEF  = 64;

  // Fixed-priority pick: 5 beats 2 beats 1.
  function automatic coin_t pick_coin(input logic any5, input logic any2, input logic any1);
    if (any5) return C5;
    if (any2) return C2;
    if (any1) return C1;
    return C_NONE;
  endfunction

endpackage

// File: rtl/vend_coin_cnt.sv
// Saturating up/down pending-coin counter; a coin on a full counter is dropped.
module vend_coin_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic up;
  logic down;

  assign full = &count;
  assign up   = inc & ~full;
  assign down = dec & (count != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (up && !down) begin
      count <= count + 1'b1;
    end else if (down && !up) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/vend_seq.sv
// Serialises coin pulses into the dfa block and runs the soda/hopper handshakes.
module vend_seq
  import vend_pkg::*;
#(
  parameter int CNT_W   = 2,
  parameter int DFA_LAT = DFA_LAT_DEF,
  parameter int TO_CYC  = TO_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic coin1,
  input  logic coin2,
  input  logic coin5,
  output logic dfa_in1,
  output logic dfa_in2,
  output logic dfa_in5,
  input  logic dfa_out1,
  input  logic dfa_out2,
  input  logic dfa_out2x2,
  input  logic dfa_soda,
  output logic soda_req,
  input  logic soda_ack,
  output logic hop_req,
  output logic hop_sel,
  input  logic hop_ack,
  output logic coin_rej,
  output logic busy,
  output logic fault
);

  localparam int TO_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;

  state_t            state;
  coin_t             win;
  logic [CNT_W-1:0]  p1, p2, p5;
  logic              full1, full2, full5;
  logic              arb, dec1, dec2, dec5, rej_any;
  logic [2:0]        wait_cnt;
  logic [2:0]        n2;
  logic              n1;
  logic [TO_W-1:0]   to_cnt;
  logic              to_hit;
  logic              hop_last;

  assign win     = pick_coin(p5 != '0, p2 != '0, p1 != '0);
  assign arb     = (state == IDLE);
  assign dec1    = arb & (win == C1);
  assign dec2    = arb & (win == C2);
  assign dec5    = arb & (win == C5);
  assign rej_any = (coin1 & full1) | (coin2 & full2) | (coin5 & full5);
  assign to_hit  = (to_cnt == TO_W'(TO_CYC - 1));
  // A 1-unit handshake is only ever issued once all 2-unit coins are paid out.
  assign hop_last = !hop_sel || (n2 == 3'd1 && !n1);

  vend_coin_cnt #(.CNT_W(CNT_W)) u_cnt1 (
    .clk(clk), .rst_n(rst_n), .inc(coin1), .dec(dec1), .count(p1), .full(full1)
  );
  vend_coin_cnt #(.CNT_W(CNT_W)) u_cnt2 (
    .clk(clk), .rst_n(rst_n), .inc(coin2), .dec(dec2), .count(p2), .full(full2)
  );
  vend_coin_cnt #(.CNT_W(CNT_W)) u_cnt5 (
    .clk(clk), .rst_n(rst_n), .inc(coin5), .dec(dec5), .count(p5), .full(full5)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dfa_in1  <= 1'b0;
      dfa_in2  <= 1'b0;
      dfa_in5  <= 1'b0;
      soda_req <= 1'b0;
      hop_req  <= 1'b0;
      hop_sel  <= 1'b0;
      coin_rej <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
      wait_cnt <= '0;
      n2       <= '0;
      n1       <= 1'b0;
      to_cnt   <= '0;
    end else begin
      dfa_in1  <= 1'b0;
      dfa_in2  <= 1'b0;
      dfa_in5  <= 1'b0;
      coin_rej <= rej_any;
      case (state)
        IDLE: begin
          if (win != C_NONE) begin
            dfa_in1 <= (win == C1);
            dfa_in2 <= (win == C2);
            dfa_in5 <= (win == C5);
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= 3'd1;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 3'(DFA_LAT)) begin
            n2     <= {1'b0, dfa_out2x2, 1'b0} + {2'b00, dfa_out2};
            n1     <= dfa_out1;
            to_cnt <= '0;
            if (dfa_soda) begin
              soda_req <= 1'b1;
              state    <= SODA;
            end else if (dfa_out1 || dfa_out2 || dfa_out2x2) begin
              state <= CHANGE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        SODA: begin
          if (soda_ack) begin
            soda_req <= 1'b0;
            to_cnt   <= '0;
            if (n1 || n2 != 3'd0) begin
              state <= CHANGE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (to_hit) begin
            soda_req <= 1'b0;
            fault    <= 1'b1;
            state    <= FAULT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        CHANGE: begin
          // hop_sel only moves while hop_req is low, so it is stable per handshake.
          if (!hop_req) begin
            hop_req <= 1'b1;
            hop_sel <= (n2 != 3'd0);
            to_cnt  <= '0;
          end else if (hop_ack) begin
            hop_req <= 1'b0;
            if (hop_sel) n2 <= n2 - 3'd1;
            else         n1 <= 1'b0;
            if (hop_last) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (to_hit) begin
            hop_req <= 1'b0;
            fault   <= 1'b1;
            state   <= FAULT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        FAULT: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_seq.sv
// Self-checking bench for vend_seq: directed scenarios plus randomized batches vs an event-order model.
`timescale 1ns/1ps
module tb_vend_seq;
  import vend_pkg::*;

  localparam int LAT    = DFA_LAT_DEF;
  localparam int TO     = TO_CYC_DEF;
  localparam int E_SODA = 10;
  localparam int E_H2   = 22;
  localparam int E_H1   = 21;

  logic clk = 1'b0;
  logic rst_n, coin1, coin2, coin5;
  logic dfa_in1, dfa_in2, dfa_in5;
  logic dfa_out1, dfa_out2, dfa_out2x2, dfa_soda;
  logic soda_req, soda_ack, hop_req, hop_sel, hop_ack;
  logic coin_rej, busy, fault;
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;
  int ev_q[$];
  int rej_seen = 0;
  int ack_dly_fixed = -1;
  logic soda_en = 1'b1, hop_en = 1'b1, spur_en = 1'b0;

  logic [3:0] rsp [8];   // per coin value: {soda, out2x2, out2, out1}
  logic [2:0] pipe [LAT];
  logic [3:0] cur_rsp;

  always #5 clk = ~clk;

  vend_seq dut (
    .clk(clk), .rst_n(rst_n), .coin1(coin1), .coin2(coin2), .coin5(coin5),
    .dfa_in1(dfa_in1), .dfa_in2(dfa_in2), .dfa_in5(dfa_in5),
    .dfa_out1(dfa_out1), .dfa_out2(dfa_out2), .dfa_out2x2(dfa_out2x2), .dfa_soda(dfa_soda),
    .soda_req(soda_req), .soda_ack(soda_ack), .hop_req(hop_req), .hop_sel(hop_sel),
    .hop_ack(hop_ack), .coin_rej(coin_rej), .busy(busy), .fault(fault)
  );

  assign outs = {dfa_in1, dfa_in2, dfa_in5, soda_req, hop_req, hop_sel, coin_rej, busy, fault};

  // dfa stand-in: answers LAT cycles after an issue pulse with the configured response
  always @(posedge clk) begin
    pipe[0] <= dfa_in5 ? 3'd5 : dfa_in2 ? 3'd2 : dfa_in1 ? 3'd1 : 3'd0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign cur_rsp    = (pipe[LAT-1] == 3'd0) ? 4'b0000 : rsp[pipe[LAT-1]];
  assign dfa_soda   = cur_rsp[3];
  assign dfa_out2x2 = cur_rsp[2];
  assign dfa_out2   = cur_rsp[1];
  assign dfa_out1   = cur_rsp[0];

  task automatic ack_step(input logic req, input logic en, inout int cnt, inout int dly,
                          output logic ack);
    ack = 1'b0;
    if (req && en) begin
      if (cnt == 0) dly = (ack_dly_fixed >= 0) ? ack_dly_fixed : int'($urandom_range(0, 5));
      ack = (cnt >= dly);
      cnt++;
    end else begin
      cnt = 0;
      ack = spur_en && !req && ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin : acker
    int s_cnt, s_dly, h_cnt, h_dly;
    s_cnt = 0; s_dly = 0; h_cnt = 0; h_dly = 0;
    soda_ack = 1'b0;
    hop_ack  = 1'b0;
    forever begin
      @(posedge clk); #1;
      ack_step(soda_req, soda_en, s_cnt, s_dly, soda_ack);
      ack_step(hop_req, hop_en, h_cnt, h_dly, hop_ack);
    end
  end

  // Event monitor: logs issues and completed handshakes, checks pulse shape and hop_sel stability
  initial begin : monitor
    logic prev_in, prev_hs, prev_hreq, prev_sel;
    prev_in = 1'b0; prev_hs = 1'b0; prev_hreq = 1'b0; prev_sel = 1'b0;
    forever begin
      @(negedge clk);
      if (dfa_in1 || dfa_in2 || dfa_in5) begin
        checks++;
        if ($countones({dfa_in1, dfa_in2, dfa_in5}) != 1 || prev_in) begin
          errors++;
          $display("FAIL issue_pulse got in5/2/1=%b%b%b prev=%b, required one-hot single-cycle",
                   dfa_in5, dfa_in2, dfa_in1, prev_in);
        end
        ev_q.push_back(dfa_in5 ? 5 : dfa_in2 ? 2 : 1);
      end
      if (soda_req && soda_ack) ev_q.push_back(E_SODA);
      if (hop_req && hop_ack) ev_q.push_back(hop_sel ? E_H2 : E_H1);
      if (hop_req && prev_hreq) begin
        checks++;
        if (hop_sel !== prev_sel) begin
          errors++;
          $display("FAIL hop_sel_stable got %b, required %b", hop_sel, prev_sel);
        end
      end
      if (prev_hs) begin
        checks++;
        if (hop_req !== 1'b0) begin
          errors++;
          $display("FAIL hop_gap got hop_req=%b after handshake, required 0", hop_req);
        end
      end
      if (coin_rej) rej_seen++;
      prev_in   = dfa_in1 | dfa_in2 | dfa_in5;
      prev_hs   = hop_req & hop_ack;
      prev_hreq = hop_req;
      prev_sel  = hop_sel;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish, required finish before 500us");
    $fatal(1, "watchdog");
  end

  // Holds the given coin pattern for ncyc cycles; returns early in the following cycle.
  task automatic pulse(input logic c1, input logic c2, input logic c5, input int ncyc);
    @(posedge clk); #1;
    coin1 = c1; coin2 = c2; coin5 = c5;
    repeat (ncyc) @(posedge clk);
    #1;
    coin1 = 1'b0; coin2 = 1'b0; coin5 = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int q = 0;
    int n = 0;
    while (q < 4 && n < budget) begin
      @(negedge clk);
      n++;
      q = busy ? 0 : q + 1;
    end
    checks++;
    if (q < 4) begin
      errors++;
      $display("FAIL %s_idle got busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 9'd0) begin
      errors++;
      $display("FAIL reset_hold got outs=%b, required 0", outs);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 9'd0) begin
      errors++;
      $display("FAIL reset_idle got outs=%b, required 0", outs);
    end
  endtask

  task automatic test_single_coin;
    pulse(1'b0, 1'b0, 1'b1, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({dfa_in5, busy} !== {k == 2, k == 2 || k == 3}) begin
        errors++;
        $display("FAIL single_t%0d got in5=%b busy=%b, required in5=%b busy=%b",
                 k, dfa_in5, busy, k == 2, k == 2 || k == 3);
      end
    end
    wait_quiet(50, "single");
  endtask

  task automatic test_simultaneous;
    int exp_q[$];
    int r0;
    exp_q = '{5, 2, 1};
    r0 = rej_seen;
    ev_q.delete();
    pulse(1'b1, 1'b1, 1'b1, 1);
    wait_quiet(100, "simul");
    checks++;
    if (ev_q != exp_q) begin
      errors++;
      $display("FAIL simul_order got %p, required %p", ev_q, exp_q);
    end
    checks++;
    if (rej_seen != r0) begin
      errors++;
      $display("FAIL simul_rej got %0d pulses, required 0", rej_seen - r0);
    end
  endtask

  task automatic test_overflow;
    int exp_q[$];
    int r0, n;
    exp_q = '{5, E_SODA, 1, 1, 1};
    rsp[5] = 4'b1000;
    soda_en = 1'b0;
    ev_q.delete();
    r0 = rej_seen;
    pulse(1'b0, 1'b0, 1'b1, 1);
    n = 0;
    while (!soda_req && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (soda_req !== 1'b1) begin
      errors++;
      $display("FAIL ovf_soda_req got %b, required 1", soda_req);
    end
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1);
      @(negedge clk);
      checks++;
      if (coin_rej !== (i == 3)) begin
        errors++;
        $display("FAIL ovf_rej_%0d got %b, required %b", i, coin_rej, i == 3);
      end
    end
    checks++;
    if (rej_seen - r0 != 1) begin
      errors++;
      $display("FAIL ovf_rej_count got %0d, required 1", rej_seen - r0);
    end
    soda_en = 1'b1;
    wait_quiet(200, "ovf");
    checks++;
    if (ev_q != exp_q) begin
      errors++;
      $display("FAIL ovf_order got %p, required %p", ev_q, exp_q);
    end
    rsp[5] = 4'b0000;
  endtask

  task automatic test_vend_change;
    int exp_q[$];
    exp_q = '{5, E_SODA, E_H2, E_H2, E_H1};
    rsp[5] = 4'b1101;
    foreach (exp_q[j]) ;
    for (int d = 0; d <= 5; d += 5) begin
      ack_dly_fixed = d;
      ev_q.delete();
      pulse(1'b0, 1'b0, 1'b1, 1);
      wait_quiet(200, "vend");
      checks++;
      if (ev_q != exp_q) begin
        errors++;
        $display("FAIL vend_dly%0d got %p, required %p", d, ev_q, exp_q);
      end
    end
    ack_dly_fixed = -1;
    rsp[5] = 4'b0000;
  endtask

  task automatic test_random;
    logic [2:0] pat [3];   // {coin5, coin2, coin1} per cycle
    int exp_q[$];
    int kcnt [8];
    int order[$];
    int win, r0, n2;
    spur_en = 1'b1;
    for (int b = 0; b < 25; b++) begin
      pat[0] = 3'($urandom_range(1, 7));
      pat[1] = 3'($urandom_range(0, 7));
      pat[2] = 3'($urandom_range(0, 7));
      rsp[1] = 4'($urandom_range(0, 15));
      rsp[2] = 4'($urandom_range(0, 15));
      rsp[5] = 4'($urandom_range(0, 15));
      kcnt[1] = pat[0][0] + pat[1][0] + pat[2][0];
      kcnt[2] = pat[0][1] + pat[1][1] + pat[2][1];
      kcnt[5] = pat[0][2] + pat[1][2] + pat[2][2];
      // the first arbitration only sees the first cycle's coins; the rest queue by priority
      win = pat[0][2] ? 5 : pat[0][1] ? 2 : 1;
      kcnt[win]--;
      order = '{win};
      foreach (order[j]) ;
      for (int c = 0; c < kcnt[5]; c++) order.push_back(5);
      for (int c = 0; c < kcnt[2]; c++) order.push_back(2);
      for (int c = 0; c < kcnt[1]; c++) order.push_back(1);
      exp_q.delete();
      foreach (order[j]) begin
        exp_q.push_back(order[j]);
        if (rsp[order[j]][3]) exp_q.push_back(E_SODA);
        n2 = int'(rsp[order[j]][1]) + 2 * int'(rsp[order[j]][2]);
        for (int c = 0; c < n2; c++) exp_q.push_back(E_H2);
        if (rsp[order[j]][0]) exp_q.push_back(E_H1);
      end
      ev_q.delete();
      r0 = rej_seen;
      for (int t = 0; t < 3; t++) begin
        @(posedge clk); #1;
        {coin5, coin2, coin1} = pat[t];
      end
      @(posedge clk); #1;
      {coin5, coin2, coin1} = 3'b000;
      wait_quiet(2000, "rand");
      checks++;
      if (ev_q != exp_q) begin
        errors++;
        $display("FAIL rand_b%0d got %p, required %p", b, ev_q, exp_q);
      end
      checks++;
      if (rej_seen != r0) begin
        errors++;
        $display("FAIL rand_rej_b%0d got %0d pulses, required 0", b, rej_seen - r0);
      end
    end
    spur_en = 1'b0;
    rsp[1] = 4'b0000; rsp[2] = 4'b0000; rsp[5] = 4'b0000;
  endtask

  task automatic test_timeout;
    int n, hi;
    rsp[2] = 4'b0010;
    hop_en = 1'b0;
    ev_q.delete();
    pulse(1'b0, 1'b1, 1'b0, 1);
    n = 0;
    while (!hop_req && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (hop_req !== 1'b1) begin
      errors++;
      $display("FAIL to_hop_req got %b, required 1", hop_req);
    end
    hi = hop_req ? 1 : 0;
    while (hop_req && hi < 200) begin
      @(negedge clk);
      if (hop_req) hi++;
    end
    checks++;
    if (hi != TO) begin
      errors++;
      $display("FAIL to_req_len got %0d cycles, required %0d", hi, TO);
    end
    checks++;
    if ({fault, hop_req, busy} !== 3'b101) begin
      errors++;
      $display("FAIL to_state got fault/hop_req/busy=%b, required 101", {fault, hop_req, busy});
    end
    pulse(1'b1, 1'b0, 1'b1, 1);
    repeat (20) @(negedge clk);
    checks++;
    if (ev_q.size() != 1) begin
      errors++;
      $display("FAIL to_no_issue got %0d events, required 1", ev_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1);
      @(negedge clk);
      checks++;
      if (coin_rej !== (i == 2)) begin
        errors++;
        $display("FAIL to_rej_%0d got %b, required %b", i, coin_rej, i == 2);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 9'd0) begin
      errors++;
      $display("FAIL to_reset got outs=%b, required 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hop_en = 1'b1;
    rsp[2] = 4'b0000;
    ev_q.delete();
    repeat (20) @(negedge clk);
    checks++;
    if (ev_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_post_reset got %0d events busy=%b, required 0 events busy=0",
               ev_q.size(), busy);
    end
  endtask

  task automatic test_async_reset;
    ev_q.delete();
    pulse(1'b0, 1'b1, 1'b0, 3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 9'd0) begin
      errors++;
      $display("FAIL async_now got outs=%b, required 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (ev_q.size() != 1 || ev_q[0] != 2) begin
      errors++;
      $display("FAIL async_after got %p, required '{2}", ev_q);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    coin1 = 1'b0; coin2 = 1'b0; coin5 = 1'b0;
    foreach (rsp[i]) rsp[i] = 4'b0000;
    test_reset;
    test_single_coin;
    test_simultaneous;
    test_overflow;
    test_vend_change;
    test_random;
    test_timeout;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
